// File: rtl/ysram_arbiter.sv
// rtl/ysram_arbiter.sv - two-requester round-robin read arbiter for the Y-matrix SRAM
module ysram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 256,
    parameter int RD_LAT = 2,
    parameter int ROWS   = 1500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              rowReq_valid,
    input  logic [ADDR_W-1:0] rowReq_addr,
    output logic              rowReq_ready,
    input  logic              adrReq_valid,
    input  logic [ADDR_W-1:0] adrReq_addr,
    output logic              adrReq_ready,
    output logic              sram_ce,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              rowRsp_valid,
    output logic              adrRsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [31:0] ROWS_U = 32'(ROWS);

    // r_rst_done keeps both readies low for the first cycle after reset release
    logic              r_rst_done;
    // r_rr_adr = 1 means the address engine wins the next contention
    logic              r_rr_adr;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_rsp_data;
    // tag pipeline: stage k is valid k+1 cycles after acceptance
    logic [RD_LAT:0]   r_tag_v;
    logic [RD_LAT:0]   r_tag_adr;
    logic [RD_LAT:0]   r_tag_err;

    logic              w_en;
    logic              w_row_gnt;
    logic              w_adr_gnt;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic              w_err;
    logic              w_ce;

    // grant selection: sole requester wins, contention goes to the pointer's side
    always_comb begin
        w_en      = reset & r_rst_done & ~hold;
        w_row_gnt = w_en & rowReq_valid & (~adrReq_valid | ~r_rr_adr);
        w_adr_gnt = w_en & adrReq_valid & (~rowReq_valid | r_rr_adr);
        w_accept  = w_row_gnt | w_adr_gnt;
        w_addr    = w_row_gnt ? rowReq_addr : adrReq_addr;
        w_err     = (32'(w_addr) >= ROWS_U);
        w_ce      = w_accept & ~w_err;
    end

    assign rowReq_ready = w_row_gnt;
    assign adrReq_ready = w_adr_gnt;
    assign sram_ce      = w_ce;
    assign sram_addr    = w_ce ? w_addr : r_sram_addr;

    // responses come straight off the last tag stage; masked while reset is low
    assign rowRsp_valid = reset & r_tag_v[RD_LAT] & ~r_tag_adr[RD_LAT];
    assign adrRsp_valid = reset & r_tag_v[RD_LAT] &  r_tag_adr[RD_LAT];
    assign rsp_err      = reset & r_tag_v[RD_LAT] &  r_tag_err[RD_LAT];
    assign rsp_data     = r_rsp_data;
    assign busy         = rowReq_valid | adrReq_valid | (|r_tag_v);

    // reset-release flag and round-robin pointer (moves only on an accept)
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rst_done <= 1'b0;
            r_rr_adr   <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_rr_adr <= w_row_gnt;
            end
        end
    end

    // remember the last issued SRAM address so it holds between reads
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sram_addr <= '0;
        end else if (w_ce) begin
            r_sram_addr <= w_addr;
        end
    end

    // shift {valid, requester, err} one stage per cycle; reset drops in-flight reads
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tag_v   <= '0;
            r_tag_adr <= '0;
            r_tag_err <= '0;
        end else begin
            r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_accept};
            r_tag_adr <= {r_tag_adr[RD_LAT-1:0], w_adr_gnt};
            r_tag_err <= {r_tag_err[RD_LAT-1:0], w_err};
        end
    end

    // capture SRAM data in the cycle it is valid; error slots load zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rsp_data <= '0;
        end else if (r_tag_v[RD_LAT-1]) begin
            r_rsp_data <= r_tag_err[RD_LAT-1] ? '0 : sram_rdata;
        end
    end

endmodule

// File: doc/ysram_arbiter.md
YSRAM_ARBITER -- requirements
Module: ysram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, Y-matrix SRAM row-address width.
REQ-002 Parameter DATA_W, default 256, SRAM row width in bits.
REQ-003 Parameter RD_LAT, default 2, SRAM read latency in cycles (legal 1..4).
REQ-004 Parameter ROWS, default 1500, number of valid SRAM rows.
REQ-005 clock  in  1  single clock; all state SHALL update on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 hold  in  1  1 = stop accepting new requests; in-flight reads complete.
REQ-008 rowReq_valid  in  1  row-engine request valid.
REQ-009 rowReq_addr  in  ADDR_W  row-engine read address.
REQ-010 rowReq_ready  out  1  row-engine request accepted this cycle.
REQ-011 adrReq_valid  in  1  address-engine request valid.
REQ-012 adrReq_addr  in  ADDR_W  address-engine read address.
REQ-013 adrReq_ready  out  1  address-engine request accepted this cycle.
REQ-014 sram_ce  out  1  SRAM read enable.
REQ-015 sram_addr  out  ADDR_W  SRAM read address.
REQ-016 sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after sram_ce.
REQ-017 rowRsp_valid  out  1  one-cycle pulse: rsp_data belongs to row engine.
REQ-018 adrRsp_valid  out  1  one-cycle pulse: rsp_data belongs to address engine.
REQ-019 rsp_data  out  DATA_W  registered read data shared by both responders.
REQ-020 rsp_err  out  1  qualifies a response pulse: address was >= ROWS.
REQ-021 busy  out  1  1 while any request is pending or any read is in flight.

Function
REQ-022 Handshake: a request is accepted in cycle N when valid and ready are both 1; the requester SHALL hold valid/addr stable until accepted.
REQ-023 At most one of rowReq_ready/adrReq_ready SHALL be 1 per cycle; both SHALL be 0 while hold=1 or reset=0.
REQ-024 Ready SHALL be combinational from valid, hold and the round-robin pointer; no request SHALL wait on an idle SRAM (one issue per cycle).
REQ-025 Arbitration: single requester valid -> granted; both valid -> grant the one not granted at the previous grant; pointer SHALL update only on an accepted grant; after reset the row engine has priority.
REQ-026 In acceptance cycle N with addr < ROWS, sram_ce=1 and sram_addr=accepted addr combinationally in cycle N; otherwise sram_ce=0 and sram_addr holds its last driven value.
REQ-027 Addr >= ROWS SHALL be accepted without an SRAM access and tagged as error.
REQ-028 A tag pipeline RD_LAT+1 stages deep SHALL carry {valid, requester, err} per accepted request.
REQ-029 Response for a request accepted in cycle N SHALL appear in cycle N+RD_LAT+1: exactly one of rowRsp_valid/adrRsp_valid high for one cycle, rsp_data = sram_rdata sampled in cycle N+RD_LAT.
REQ-030 Error response: same latency, rsp_err=1, rsp_data=0; rsp_err SHALL be 0 whenever no response pulse is asserted.
REQ-031 Responses SHALL return in acceptance order; back-to-back accepts SHALL produce back-to-back responses; responders have no backpressure.
REQ-032 rsp_data SHALL hold its last value between pulses.
REQ-033 hold asserted mid-stream SHALL block new accepts from the same cycle; all in-flight responses SHALL still be delivered.
REQ-034 busy = rowReq_valid | adrReq_valid | any tag-stage valid.

Reset
REQ-035 While reset=0 at a rising edge: all tag stages invalid, round-robin pointer = row engine, rsp_data=0, sram_addr=0.
REQ-036 Outputs during and the cycle after reset: all ready, sram_ce, *Rsp_valid, rsp_err = 0; busy reflects request valids only.
REQ-037 Reads in flight at reset SHALL be discarded; no response pulse SHALL be generated for them.

Verification
REQ-038 Single read: rowReq addr=5 accepted cycle 10, RD_LAT=2, sram_rdata=0xA5..A5 in cycle 12 -> sram_ce=1/addr=5 in cycle 10, rowRsp_valid=1 with 0xA5..A5 in cycle 13 only.
REQ-039 Contention: both valid continuously, 6 cycles -> grants alternate row,adr,row,adr,row,adr; responses in the same order, 6 consecutive pulses.
REQ-040 Out of range: adrReq addr=1500 -> sram_ce=0 that cycle, adrRsp_valid=1 with rsp_err=1, rsp_data=0 at N+RD_LAT+1.
REQ-041 Hold: 3 back-to-back accepts, hold=1 on the next cycle with requests still valid -> no further ready; 3 responses delivered; busy stays 1 while valids remain.
REQ-042 Reset mid-flight: accept 2 reads, reset=0 the next cycle for one cycle -> no response pulses; next accept goes to row engine when both valid.
REQ-043 Latency sweep: repeat REQ-038 for RD_LAT=1 and 4 -> response at N+2 and N+5.
